mdu_unit: RTL and testbench
===========================

MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, the busy duration of MULT/MULTU in cycles.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, the busy duration of DIV/DIVU in cycles.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Req  input  1  exception/interrupt request; suppresses E-stage instruction side effects.
REQ-006 SHALL have port mdu_op  input  4  operation from E-stage decode: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-007 SHALL have port A  input  32  rs operand (forwarded E-stage value).
REQ-008 SHALL have port B  input  32  rt operand (forwarded E-stage value).
REQ-009 SHALL have port start  output  1  combinational; high when mdu_op is MULT/MULTU/DIV/DIVU, busy=0 and Req=0.
REQ-010 SHALL have port busy  output  1  registered; high while a multiply/divide is in progress.
REQ-011 SHALL have port HI  output  32  architectural HI register.
REQ-012 SHALL have port LO  output  32  architectural LO register.
REQ-013 SHALL have port rdata  output  32  combinational; HI when mdu_op=MFHI, LO when mdu_op=MFLO, else 0.

Function
REQ-014 On the edge where start=1, the block SHALL latch the full result into internal temp_hi/temp_lo and load the cycle counter with MULT_CYCLES or DIV_CYCLES.
REQ-015 busy SHALL be 1 from the first edge after the start edge until the edge that commits the result, i.e. exactly N cycles for a duration of N.
REQ-016 HI/LO SHALL take temp_hi/temp_lo on the edge where the counter decrements 1->0; busy falls on the same edge.
REQ-017 Results SHALL therefore be visible on HI/LO exactly N cycles after the start edge.
REQ-018 MULT SHALL compute the signed 64-bit product of A*B, and MULTU the unsigned product; product[63:32] goes to HI and product[31:0] to LO.
REQ-019 DIV SHALL compute a signed quotient, truncated toward zero, into LO and the remainder, carrying the dividend's sign, into HI.
REQ-020 DIVU SHALL compute the unsigned quotient into LO and the unsigned remainder into HI.
REQ-021 Division with B=0 SHALL still assert busy for DIV_CYCLES cycles and SHALL leave HI/LO unchanged at commit.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-023 MTHI/MTLO SHALL write A into HI/LO on the edge when busy=0 and Req=0; the write is ignored when either is high.
REQ-024 A mult/div op presented while busy=1 SHALL be ignored; upstream stall logic guarantees this does not happen and must use start|busy.
REQ-025 Req=1 together with a mult/div op SHALL suppress start, leaving counter, HI and LO unchanged.
REQ-026 Req=1 during an in-progress operation SHALL NOT abort it; the operation commits normally because its instruction has already retired past E.
REQ-027 MFHI/MFLO during busy SHALL return the pre-commit HI/LO value; the hazard unit stalls such reads.

Reset
REQ-028 reset=1 SHALL clear HI, LO, temp_hi, temp_lo and the counter to 0 and set busy=0 on the next edge.
REQ-029 reset SHALL take priority over all other inputs.
REQ-030 reset mid-operation SHALL abort the operation with no commit.

Structure
REQ-031 The mdu_op encodings and the default MULT_CYCLES/DIV_CYCLES constants SHALL live in shared package mdu_pkg, also used by the decoder.
REQ-032 The block SHALL be a single module: counter plus HI/LO/temp registers, with combinational multiply/divide computed at start.
REQ-033 The combinational multiply/divide MAY be factored into one sub-module, mdu_calc, which SHALL be purely combinational.

Verification
REQ-034 MULT A=0xFFFFFFFF, B=2 -> busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-035 MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-036 DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-037 DIVU A=7, B=0 with HI=0x11, LO=0x22 -> busy 10 cycles; HI/LO unchanged.
REQ-038 MULT with Req=1 -> start=0, busy stays 0, HI/LO unchanged; MTLO A=0x5 with Req=1 -> LO unchanged.
REQ-039 Start DIV, assert reset at cycle 4 -> busy=0 and HI=LO=0 next cycle, with no later commit.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared mdu_op encodings and default latency constants
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational multiply/divide producing the full HI/LO result
import mdu_pkg::*;

module mdu_calc (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_valid
);

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quot;
    logic [31:0] rem;

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
    always_comb begin
        signed_op = (op == MDU_MULT) || (op == MDU_DIV);
        a_neg     = signed_op & a[31];
        b_neg     = signed_op & b[31];
        ext_a     = {{32{a_neg}}, a};
        ext_b     = {{32{b_neg}}, b};
        product   = ext_a * ext_b;
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;
        quot      = 32'd0;
        rem       = 32'd0;
        if (b != 32'd0) begin
            quot = mag_a / mag_b;
            rem  = mag_a % mag_b;
        end

        res_hi    = 32'd0;
        res_lo    = 32'd0;
        res_valid = 1'b0;
        case (op)
            MDU_MULT, MDU_MULTU: begin
                res_hi    = product[63:32];
                res_lo    = product[31:0];
                res_valid = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
                res_lo    = (a_neg ^ b_neg) ? -quot : quot;
                res_hi    = a_neg ? -rem : rem;
                res_valid = (b != 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle MIPS HI/LO multiply/divide unit with fixed latency
import mdu_pkg::*;

module mdu_unit #(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] rdata
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    logic [CW-1:0] cnt;
    logic [31:0]   temp_hi;
    logic [31:0]   temp_lo;
    logic [31:0]   calc_hi;
    logic [31:0]   calc_lo;
    logic          calc_valid;
    logic          is_mul;
    logic          is_div;

    mdu_calc u_calc (
        .op        (mdu_op),
        .a         (A),
        .b         (B),
        .res_hi    (calc_hi),
        .res_lo    (calc_lo),
        .res_valid (calc_valid)
    );

    assign is_mul = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU);
    assign is_div = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
    assign start  = (is_mul | is_div) & ~busy & ~Req;

    // Divide-by-zero snapshots the current HI/LO so the commit rewrites the same values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            busy    <= 1'b0;
            temp_hi <= 32'd0;
            temp_lo <= 32'd0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else if (start) begin
            cnt     <= is_div ? DIV_N : MULT_N;
            busy    <= 1'b1;
            temp_hi <= calc_valid ? calc_hi : HI;
            temp_lo <= calc_valid ? calc_lo : LO;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                HI   <= temp_hi;
                LO   <= temp_lo;
                busy <= 1'b0;
            end
        end else if (!Req) begin
            if (mdu_op == MDU_MTHI) HI <= A;
            if (mdu_op == MDU_MTLO) LO <= A;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (mdu_op == MDU_MFHI) rdata = HI;
        if (mdu_op == MDU_MFLO) rdata = LO;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - table-driven self-checking bench for mdu_unit with result scoreboard
import mdu_pkg::*;

module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic        Req;
    logic [3:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] rdata;

    int total;
    int bad;

    typedef struct {
        mdu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t vecs[11];
    exp_t sb[$];

    mdu_unit dut (
        .clk    (clk),
        .reset  (reset),
        .Req    (Req),
        .mdu_op (mdu_op),
        .A      (A),
        .B      (B),
        .start  (start),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        Req = 1'b0;
        mdu_op = MDU_MTHI; A = h;
        tick();
        mdu_op = MDU_MTLO; A = l;
        tick();
        mdu_op = MDU_NONE; A = 32'd0;
    endtask

    // Counts edges until busy drops, bounded so a stuck busy shows up as a length mismatch.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   cyc;
        exp_t e;
        write_hilo(32'h11, 32'h22);
        mdu_op = v.op; A = v.a; B = v.b;
        #1;
        check($sformatf("v%0d start", idx), 32'(start), 32'd1);
        sb.push_back('{hi: v.hi, lo: v.lo});
        tick();
        mdu_op = MDU_MFHI; A = 32'd0; B = 32'd0;
        #1;
        check($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
        check($sformatf("v%0d mfhi_pre", idx), rdata, 32'h11);
        wait_idle(cyc);
        check($sformatf("v%0d cycles", idx), 32'(cyc), 32'(v.n));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("v%0d HI", idx), HI, e.hi);
            check($sformatf("v%0d LO", idx), LO, e.lo);
            mdu_op = MDU_MFLO;
            #1;
            check($sformatf("v%0d mflo", idx), rdata, e.lo);
        end else begin
            check($sformatf("v%0d sb_empty", idx), 32'd0, 32'd1);
        end
        mdu_op = MDU_NONE;
    endtask

    initial begin
        int cyc;
        total = 0;
        bad   = 0;
        vecs[0]  = '{MDU_MULT,  32'hFFFFFFFF, 32'h00000002,  5, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'h00000002,  5, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MDU_DIVU,  32'h00000007, 32'h00000000, 10, 32'h00000011, 32'h00000022};
        vecs[4]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[5]  = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF,  5, 32'h00000000, 32'h00000001};
        vecs[6]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,  5, 32'hFFFFFFFE, 32'h00000001};
        vecs[7]  = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{MDU_DIVU,  32'h00000064, 32'h00000007, 10, 32'h00000002, 32'h0000000E};
        vecs[9]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000000, 10, 32'h00000011, 32'h00000022};
        vecs[10] = '{MDU_MULT,  32'h80000000, 32'h80000000,  5, 32'h40000000, 32'h00000000};

        reset = 1'b1; Req = 1'b0; mdu_op = MDU_NONE; A = 32'd0; B = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst HI", HI, 32'd0);
        check("rst LO", LO, 32'd0);
        check("rst start", 32'(start), 32'd0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Req suppresses start and MTLO.
        write_hilo(32'h33, 32'h44);
        Req = 1'b1; mdu_op = MDU_MULT; A = 32'h3; B = 32'h4;
        #1;
        check("req start", 32'(start), 32'd0);
        tick();
        check("req busy", 32'(busy), 32'd0);
        check("req HI", HI, 32'h33);
        check("req LO", LO, 32'h44);
        mdu_op = MDU_MTLO; A = 32'h5;
        tick();
        check("req mtlo", LO, 32'h44);
        Req = 1'b0; mdu_op = MDU_NONE;

        // While busy: new ops, MTHI ignored; Req mid-flight does not abort.
        mdu_op = MDU_MULTU; A = 32'h10; B = 32'h10;
        tick();
        mdu_op = MDU_DIV; A = 32'h9; B = 32'h3;
        #1;
        check("busy start", 32'(start), 32'd0);
        tick();
        mdu_op = MDU_MTHI; A = 32'hDEAD;
        Req = 1'b1;
        tick();
        mdu_op = MDU_NONE; Req = 1'b0;
        wait_idle(cyc);
        check("busy cycles", 32'(cyc + 2), 32'd5);
        check("busy HI", HI, 32'h0);
        check("busy LO", LO, 32'h100);

        // Reset during a divide aborts with no later commit.
        write_hilo(32'h55, 32'h66);
        mdu_op = MDU_DIVU; A = 32'd100; B = 32'd3;
        tick();
        mdu_op = MDU_NONE;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort HI", HI, 32'd0);
        check("abort LO", LO, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("abort late HI", HI, 32'd0);
        check("abort late LO", LO, 32'd0);
        check("abort late busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
